// File: rtl/vt52_cmd_engine.sv
// VT52 command engine: turns a received byte stream into char-buffer,
// cursor and scroll-offset writes, with multi-cycle clear/scroll/erase fills.
module vt52_cmd_engine #(
  parameter int ROWS      = 25,
  parameter int COLS      = 80,
  parameter int ROW_BITS  = 5,
  parameter int COL_BITS  = 7,
  parameter int ADDR_BITS = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           data,
  input  logic                 valid,
  output logic                 ready,
  output logic [7:0]           new_char,
  output logic [ADDR_BITS-1:0] new_char_address,
  output logic                 new_char_wen,
  output logic [COL_BITS-1:0]  new_cursor_x,
  output logic [ROW_BITS-1:0]  new_cursor_y,
  output logic                 new_cursor_wen,
  output logic [ADDR_BITS-1:0] new_first_char,
  output logic                 new_first_char_wen
);

  typedef logic [ADDR_BITS:0]   wa_t;
  typedef logic [ADDR_BITS-1:0] ad_t;
  typedef logic [COL_BITS-1:0]  cx_t;
  typedef logic [COL_BITS:0]    cw_t;
  typedef logic [ROW_BITS-1:0]  ry_t;

  typedef enum logic [2:0] {
    CLEAR, IDLE, ESC, ESC_Y_ROW, ESC_Y_COL, FILL
  } st_t;

  localparam wa_t CELLS_W = wa_t'(ROWS * COLS);
  localparam wa_t COLS_W  = wa_t'(COLS);
  localparam wa_t LAST_W  = wa_t'((ROWS - 1) * COLS);
  localparam cx_t XMAX    = cx_t'(COLS - 1);
  localparam ry_t YMAX    = ry_t'(ROWS - 1);

  st_t st_q, st_d;
  cx_t x_q, x_d;
  ry_t y_q, y_d;
  ry_t row_q, row_d;
  ad_t fc_q;
  ad_t fa_q;
  wa_t fn_q;

  logic rdy_q, cw_q, cuw_q, fw_q;
  logic [7:0] ch_q;
  ad_t ca_q, fo_q;
  cx_t cx_q;
  ry_t cy_q;

  logic wr, scroll, fill;
  wa_t  lin, fcnt;
  ad_t  cur_addr, fc_nx, bot, fa_inc;
  cw_t  tab;

  function automatic ad_t wrap(input wa_t v);
    wa_t r;
    r = (v >= CELLS_W) ? v - CELLS_W : v;
    return r[ADDR_BITS-1:0];
  endfunction

  // ESC Y coordinates are offset by 0x20 and clamped into the screen
  function automatic logic [7:0] yclamp(input logic [7:0] b,
                                        input logic [7:0] mx);
    logic [7:0] v;
    v = b - 8'h20;
    if (b < 8'h20) return 8'h00;
    if (v > mx) return mx;
    return v;
  endfunction

  always_comb begin
    lin      = wa_t'(y_q) * COLS_W + wa_t'(x_q);
    cur_addr = wrap(wa_t'(fc_q) + lin);
    fc_nx    = wrap(wa_t'(fc_q) + COLS_W);
    bot      = wrap(wa_t'(fc_nx) + LAST_W);
    fa_inc   = wrap(wa_t'(fa_q) + wa_t'(1));
    tab      = (cw_t'(x_q) | cw_t'(7)) + cw_t'(1);
    st_d     = IDLE;
    x_d      = x_q;
    y_d      = y_q;
    row_d    = row_q;
    wr       = 1'b0;
    scroll   = 1'b0;
    fill     = 1'b0;
    fcnt     = '0;
    unique case (st_q)
      IDLE: begin
        unique case (1'b1)
          (data >= 8'h20 && data <= 8'h7e): begin
            wr = 1'b1;
            if (x_q == XMAX) begin
              x_d = '0;
              if (y_q == YMAX) scroll = 1'b1;
              else y_d = y_q + 1'b1;
            end else begin
              x_d = x_q + 1'b1;
            end
          end
          (data == 8'h0d): x_d = '0;
          (data == 8'h0a): begin
            if (y_q == YMAX) scroll = 1'b1;
            else y_d = y_q + 1'b1;
          end
          (data == 8'h08): if (x_q != '0) x_d = x_q - 1'b1;
          (data == 8'h09):
            x_d = (tab > cw_t'(COLS - 1)) ? XMAX : cx_t'(tab);
          (data == 8'h1b): st_d = ESC;
          default: ;
        endcase
      end
      ESC: begin
        unique case (1'b1)
          (data == 8'h41): if (y_q != '0) y_d = y_q - 1'b1;
          (data == 8'h42): if (y_q != YMAX) y_d = y_q + 1'b1;
          (data == 8'h43): if (x_q != XMAX) x_d = x_q + 1'b1;
          (data == 8'h44): if (x_q != '0) x_d = x_q - 1'b1;
          (data == 8'h48): begin
            x_d = '0;
            y_d = '0;
          end
          (data == 8'h4a): begin
            fill = 1'b1;
            fcnt = CELLS_W - lin;
          end
          (data == 8'h4b): begin
            fill = 1'b1;
            fcnt = COLS_W - wa_t'(x_q);
          end
          (data == 8'h59): st_d = ESC_Y_ROW;
          default: ;
        endcase
      end
      ESC_Y_ROW: begin
        row_d = ry_t'(yclamp(data, 8'(ROWS - 1)));
        st_d  = ESC_Y_COL;
      end
      ESC_Y_COL: begin
        y_d = row_q;
        x_d = cx_t'(yclamp(data, 8'(COLS - 1)));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q  <= CLEAR;
      x_q   <= '0;
      y_q   <= '0;
      row_q <= '0;
      fc_q  <= '0;
      fa_q  <= '0;
      fn_q  <= CELLS_W;
      rdy_q <= 1'b0;
      ch_q  <= 8'h20;
      ca_q  <= '0;
      cw_q  <= 1'b0;
      cx_q  <= '0;
      cy_q  <= '0;
      cuw_q <= 1'b0;
      fo_q  <= '0;
      fw_q  <= 1'b0;
    end else begin
      cw_q  <= 1'b0;
      cuw_q <= 1'b0;
      fw_q  <= 1'b0;
      unique case (st_q)
        CLEAR, FILL: begin
          if (fn_q != '0) begin
            cw_q <= 1'b1;
            ch_q <= 8'h20;
            ca_q <= fa_q;
            fa_q <= fa_inc;
            fn_q <= fn_q - 1'b1;
          end else begin
            // one idle cycle after the last write before reopening input
            rdy_q <= 1'b1;
            cuw_q <= 1'b1;
            cx_q  <= x_q;
            cy_q  <= y_q;
            st_q  <= IDLE;
            if (st_q == CLEAR) begin
              fw_q <= 1'b1;
              fo_q <= fc_q;
            end
          end
        end
        default: begin
          if (valid && rdy_q) begin
            st_q  <= st_d;
            x_q   <= x_d;
            y_q   <= y_d;
            row_q <= row_d;
            cuw_q <= 1'b1;
            cx_q  <= x_d;
            cy_q  <= y_d;
            if (wr) begin
              cw_q <= 1'b1;
              ch_q <= data;
              ca_q <= cur_addr;
            end
            if (scroll) begin
              fc_q  <= fc_nx;
              fo_q  <= fc_nx;
              fw_q  <= 1'b1;
              st_q  <= FILL;
              fa_q  <= bot;
              fn_q  <= COLS_W;
              rdy_q <= 1'b0;
            end
            if (fill) begin
              st_q  <= FILL;
              fa_q  <= cur_addr;
              fn_q  <= fcnt;
              rdy_q <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign ready              = rdy_q;
  assign new_char           = ch_q;
  assign new_char_address   = ca_q;
  assign new_char_wen       = cw_q;
  assign new_cursor_x       = cx_q;
  assign new_cursor_y       = cy_q;
  assign new_cursor_wen     = cuw_q;
  assign new_first_char     = fo_q;
  assign new_first_char_wen = fw_q;

endmodule
